// File: rtl/huff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : huff_pkg
// Description : Shared state encodings, default widths and width helpers for
//               the Huffman encoder chain.
// Revision    : 1.0
// ============================================================================
package huff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic int len_width(input int max_code_len);
        return $clog2(max_code_len + 1);
    endfunction

    function automatic int acc_width(input int out_width, input int max_code_len);
        return out_width + max_code_len;
    endfunction

    // Code-entry field widths shared with the code-generation stage.
    localparam int C_DEF_BIT_WIDTH    = 8;
    localparam int C_DEF_MAX_CODE_LEN = 16;
    localparam int C_DEF_OUT_WIDTH    = 32;
    localparam int C_DEF_CNT_WIDTH    = 32;
    localparam int C_DEF_LEN_WIDTH    = len_width(C_DEF_MAX_CODE_LEN);

endpackage
`default_nettype wire

// File: rtl/huff_bit_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : huff_bit_packer_if
// Description : Table-load, symbol-stream and packed-word stream signals.
// Revision    : 1.0
// ============================================================================
interface huff_bit_packer_if
    import huff_pkg::*;
#(
    parameter int BIT_WIDTH    = C_DEF_BIT_WIDTH,
    parameter int MAX_CODE_LEN = C_DEF_MAX_CODE_LEN,
    parameter int OUT_WIDTH    = C_DEF_OUT_WIDTH,
    parameter int LEN_WIDTH    = len_width(MAX_CODE_LEN)
);
    localparam int OB_W = $clog2(OUT_WIDTH + 1);

    logic                    tbl_wr_en;
    logic [BIT_WIDTH-1:0]    tbl_wr_sym;
    logic [MAX_CODE_LEN-1:0] tbl_wr_code;
    logic [LEN_WIDTH-1:0]    tbl_wr_len;

    logic [BIT_WIDTH-1:0]    sym_in;
    logic                    sym_valid;
    logic                    sym_last;
    logic                    sym_ready;

    logic [OUT_WIDTH-1:0]    out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic [OB_W-1:0]         out_bits;

    modport master (
        output tbl_wr_en, tbl_wr_sym, tbl_wr_code, tbl_wr_len,
        output sym_in, sym_valid, sym_last, out_ready,
        input  sym_ready, out_data, out_valid, out_last, out_bits
    );

    modport slave (
        input  tbl_wr_en, tbl_wr_sym, tbl_wr_code, tbl_wr_len,
        input  sym_in, sym_valid, sym_last, out_ready,
        output sym_ready, out_data, out_valid, out_last, out_bits
    );

endinterface
`default_nettype wire

// File: rtl/huff_code_table.sv
`default_nettype none
// ============================================================================
// Module      : huff_code_table
// Description : Per-symbol {code, len} store; sync write, combinational read.
// Revision    : 1.0
// ============================================================================
module huff_code_table
    import huff_pkg::*;
#(
    parameter int BIT_WIDTH    = C_DEF_BIT_WIDTH,
    parameter int MAX_CODE_LEN = C_DEF_MAX_CODE_LEN,
    parameter int LEN_WIDTH    = len_width(MAX_CODE_LEN)
) (
    input  wire logic                    clock,
    input  wire logic                    rst,
    input  wire logic                    wr_en,
    input  wire logic [BIT_WIDTH-1:0]    wr_sym,
    input  wire logic [MAX_CODE_LEN-1:0] wr_code,
    input  wire logic [LEN_WIDTH-1:0]    wr_len,
    input  wire logic [BIT_WIDTH-1:0]    rd_sym,
    output logic      [MAX_CODE_LEN-1:0] rd_code,
    output logic      [LEN_WIDTH-1:0]    rd_len
);
    localparam int DEPTH = 2 ** BIT_WIDTH;

    logic [MAX_CODE_LEN-1:0] r_code [DEPTH];
    logic [LEN_WIDTH-1:0]    r_len  [DEPTH];

    // Codes are meaningless while their length is zero, so only lengths reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_code[wr_sym] <= wr_code;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_len[i] <= '0;
            end
        end else if (wr_en) begin
            r_len[wr_sym] <= wr_len;
        end
    end

    assign rd_code = r_code[rd_sym];
    assign rd_len  = r_len[rd_sym];

endmodule
`default_nettype wire

// File: rtl/huff_bit_packer.sv
`default_nettype none
// ============================================================================
// Module      : huff_bit_packer
// Description : Packs variable-length Huffman codes MSB-first into fixed-width
//               left-aligned words, with a flagged zero-padded final word.
// Revision    : 1.0
// ============================================================================
module huff_bit_packer
    import huff_pkg::*;
#(
    parameter int BIT_WIDTH    = C_DEF_BIT_WIDTH,
    parameter int MAX_CODE_LEN = C_DEF_MAX_CODE_LEN,
    parameter int OUT_WIDTH    = C_DEF_OUT_WIDTH,
    parameter int LEN_WIDTH    = len_width(MAX_CODE_LEN),
    parameter int CNT_WIDTH    = C_DEF_CNT_WIDTH
) (
    input  wire logic             clock,
    input  wire logic             rst,
    input  wire logic             start,
    huff_bit_packer_if.slave      bus,
    output logic [CNT_WIDTH-1:0]  total_bits,
    output logic                  busy,
    output logic                  err_zero_len
);
    localparam int ACC_W  = acc_width(OUT_WIDTH, MAX_CODE_LEN);
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int OB_W   = $clog2(OUT_WIDTH + 1);

    localparam logic [FILL_W-1:0]    C_OUT_W   = FILL_W'(OUT_WIDTH);
    localparam logic [LEN_WIDTH-1:0] C_MAX_LEN = LEN_WIDTH'(MAX_CODE_LEN);

    state_t                  r_state;
    logic [ACC_W-1:0]        r_acc;
    logic [FILL_W-1:0]       r_fill;
    logic [CNT_WIDTH-1:0]    r_total;
    logic                    r_err;

    logic [MAX_CODE_LEN-1:0] w_rd_code;
    logic [LEN_WIDTH-1:0]    w_rd_len;
    logic [MAX_CODE_LEN-1:0] w_code_la;
    logic [ACC_W-1:0]        w_ins;
    logic                    w_word_full;
    logic                    w_last_word;
    logic                    w_accept;
    logic                    w_emit;

    huff_code_table #(
        .BIT_WIDTH    (BIT_WIDTH),
        .MAX_CODE_LEN (MAX_CODE_LEN),
        .LEN_WIDTH    (LEN_WIDTH)
    ) u_table (
        .clock   (clock),
        .rst     (rst),
        .wr_en   (bus.tbl_wr_en && (r_state == ST_IDLE)),
        .wr_sym  (bus.tbl_wr_sym),
        .wr_code (bus.tbl_wr_code),
        .wr_len  (bus.tbl_wr_len),
        .rd_sym  (bus.sym_in),
        .rd_code (w_rd_code),
        .rd_len  (w_rd_len)
    );

    // Left-align the code, then drop it just below the bits already held.
    assign w_code_la = w_rd_code << (C_MAX_LEN - w_rd_len);
    assign w_ins     = {w_code_la, {OUT_WIDTH{1'b0}}} >> r_fill;

    assign w_word_full = (r_fill >= C_OUT_W);
    assign w_last_word = (r_state == ST_FLUSH) && (r_fill <= C_OUT_W);

    assign bus.sym_ready = (r_state == ST_RUN) && !w_word_full;
    assign bus.out_valid = w_word_full || (r_state == ST_FLUSH);
    assign bus.out_last  = w_last_word;
    assign bus.out_data  = r_acc[ACC_W-1 -: OUT_WIDTH];
    assign bus.out_bits  = !bus.out_valid ? '0 :
                           w_last_word    ? OB_W'(r_fill) : OB_W'(OUT_WIDTH);

    assign w_accept = bus.sym_valid && bus.sym_ready;
    assign w_emit   = bus.out_valid && bus.out_ready;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_fill  <= '0;
            r_total <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_acc   <= '0;
                        r_fill  <= '0;
                        r_total <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_RUN, ST_FLUSH: begin
                    if (w_accept) begin
                        if (w_rd_len == '0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_acc  <= r_acc | w_ins;
                            r_fill <= r_fill + FILL_W'(w_rd_len);
                        end
                        if (bus.sym_last) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                    // Accept and emit are mutually exclusive on fill level.
                    if (w_emit) begin
                        r_acc   <= r_acc << OUT_WIDTH;
                        r_fill  <= w_word_full ? (r_fill - C_OUT_W) : '0;
                        r_total <= r_total + CNT_WIDTH'(bus.out_bits);
                        if (w_last_word) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign total_bits   = r_total;
    assign busy         = (r_state != ST_IDLE);
    assign err_zero_len = r_err;

endmodule
`default_nettype wire
